// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and FSM state type for the 3x3 window controller.
//   DEF_IMG_W / DEF_IMG_H : default image geometry (pixels per line, lines)
//   state_t               : controller FSM states
package conv_pkg;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/conv_window_ctrl_raster_counter.sv
// raster_counter: column/row position counter in raster order.
//   clk, rst : clock, synchronous active-low reset
//   i_clr    : restart at (0,0); combined with i_en the restart position is
//              itself counted, so the result is the position after (0,0)
//   i_en     : advance one position (col wraps W-1 -> 0 and bumps row,
//              row wraps H-1 -> 0 only after the last pixel)
//   o_col, o_row : current position
//   o_last   : current position is the last pixel of the frame
module raster_counter #(
  parameter int W = 640,
  parameter int H = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [$clog2(W)-1:0] o_col,
  output logic [$clog2(H)-1:0] o_row,
  output logic                 o_last
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  logic [CW-1:0] r_col, w_base_col, w_nxt_col;
  logic [RW-1:0] r_row, w_base_row, w_nxt_row;

  always_comb begin
    w_base_col = i_clr ? '0 : r_col;
    w_base_row = i_clr ? '0 : r_row;
    w_nxt_col  = w_base_col;
    w_nxt_row  = w_base_row;
    if (i_en) begin
      if (w_base_col == COL_MAX) begin
        w_nxt_col = '0;
        w_nxt_row = (w_base_row == ROW_MAX) ? '0 : w_base_row + 1'b1;
      end else begin
        w_nxt_col = w_base_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_nxt_col;
      r_row <= w_nxt_row;
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_col == COL_MAX) && (r_row == ROW_MAX);
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequencing for a 3x3 convolution line buffer. Pixel data
// never passes through here; this block only decides when the buffer shifts,
// when it loads zeros, and which centre pixel the current window belongs to.
//   clk, rst       : clock, synchronous active-low reset
//   pix_valid, sof : upstream pixel present / first pixel of frame
//   in_ready       : pixel accepted when pix_valid && in_ready
//   shift_en       : buffer shift strobe (combinational)
//   zero_fill      : buffer shifts in zero instead of pixel data (combinational)
//   pix_edge       : accepted pixel is in column 0 or IMG_W-1 (combinational)
//   win_valid      : registered, window centre valid
//   center_col/row : registered centre coordinates
//   center_border  : registered, centre lies on the image border
//   frame_done     : registered pulse alongside the last window of a frame
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic                     in_ready,
  output logic                     shift_en,
  output logic                     zero_fill,
  output logic                     pix_edge,
  output logic                     win_valid,
  output logic [$clog2(IMG_W)-1:0] center_col,
  output logic [$clog2(IMG_H)-1:0] center_row,
  output logic                     center_border,
  output logic                     frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t r_state, w_nxt_state;

  logic          w_accept, w_start, w_acc_shift, w_win, w_flush;
  logic [CW-1:0] w_in_col, w_cc_col;
  logic [RW-1:0] w_in_row, w_cc_row;
  logic          w_in_last, w_cc_last;

  logic          r_win_valid, r_border, r_frame_done;
  logic [CW-1:0] r_center_col;
  logic [RW-1:0] r_center_row;

  assign w_flush     = (r_state == FLUSH);
  assign in_ready    = !w_flush;
  assign w_accept    = pix_valid && in_ready;
  // sof restarts from any accepting state: a fresh start in IDLE, an abort otherwise
  assign w_start     = w_accept && sof;
  // in IDLE only a sof pixel is taken into the buffer; others are dropped
  assign w_acc_shift = w_accept && (sof || r_state != IDLE);
  assign w_win       = (r_state == RUN && w_accept && !sof) || w_flush;

  assign shift_en  = w_acc_shift || w_flush;
  assign zero_fill = w_flush;
  assign pix_edge  = w_acc_shift && (sof || w_in_col == '0 || w_in_col == COL_MAX);

  // input position = index of the pixel being accepted this cycle
  raster_counter #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (w_acc_shift),
    .o_col (w_in_col),
    .o_row (w_in_row),
    .o_last(w_in_last)
  );

  // centre position = coordinates of the window emitted this cycle
  raster_counter #(.W(IMG_W), .H(IMG_H)) u_cc_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (w_win),
    .o_col (w_cc_col),
    .o_row (w_cc_row),
    .o_last(w_cc_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:  if (w_start) w_nxt_state = FILL;
      FILL: begin
        if (w_start) w_nxt_state = FILL;
        // index IMG_W is the first pixel of row 1
        else if (w_accept && w_in_col == '0 && w_in_row == RW'(1)) w_nxt_state = RUN;
      end
      RUN: begin
        if (w_start)                    w_nxt_state = FILL;
        else if (w_accept && w_in_last) w_nxt_state = FLUSH;
      end
      // the centre counter reaching the last pixel marks the final flush shift
      FLUSH: if (w_cc_last) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win_valid  <= 1'b0;
      r_center_col <= '0;
      r_center_row <= '0;
      r_border     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_win;
      r_frame_done <= w_flush && w_cc_last;
      if (w_win) begin
        r_center_col <= w_cc_col;
        r_center_row <= w_cc_row;
        r_border     <= (w_cc_col == '0) || (w_cc_col == COL_MAX) ||
                        (w_cc_row == '0) || (w_cc_row == ROW_MAX);
      end
    end
  end

  assign win_valid     = r_win_valid;
  assign center_col    = r_center_col;
  assign center_row    = r_center_row;
  assign center_border = r_border;
  assign frame_done    = r_frame_done;
endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;
  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic       in_ready, shift_en, zero_fill, pix_edge, win_valid, center_border, frame_done;
  logic [1:0] center_col, center_row;

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .sof          (sof),
    .in_ready     (in_ready),
    .shift_en     (shift_en),
    .zero_fill    (zero_fill),
    .pix_edge     (pix_edge),
    .win_valid    (win_valid),
    .center_col   (center_col),
    .center_row   (center_row),
    .center_border(center_border),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: frame progress as plain integers
  int m_active = 0;   // a frame is being received
  int m_n      = 0;   // index the next accepted pixel will get
  int m_fl     = 0;   // flush cycles still to run
  int e_wv = 0, e_col = 0, e_row = 0, e_brd = 0, e_done = 0;

  // observations of the DUT, used for totals and literal pins
  int tot_win = 0, tot_shift = 0, tot_done = 0, rdy_low = 0;
  int done_col = -1, done_row = -1;
  int brd[3][4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_obs();
    tot_win = 0; tot_shift = 0; tot_done = 0; rdy_low = 0;
    done_col = -1; done_row = -1;
  endtask

  task automatic step(input bit pv, input bit s, input bit r = 1'b1);
    int acc, e_rdy, e_sh, e_zf, e_ed, w, c, dn;
    pix_valid = pv; sof = s; rst = r;
    @(negedge clk);
    e_rdy = (m_fl == 0);
    acc = pv && e_rdy;
    e_sh = 0; e_zf = 0; e_ed = 0; w = 0; c = 0; dn = 0;
    if (m_fl > 0) begin
      e_sh = 1; e_zf = 1; w = 1; c = W*H - m_fl; dn = (m_fl == 1);
    end else if (acc && s) begin
      e_sh = 1; e_ed = 1;
    end else if (acc && m_active) begin
      e_sh = 1;
      e_ed = (m_n % W == 0) || (m_n % W == W-1);
      if (m_n >= W+1) begin w = 1; c = m_n - (W+1); end
    end
    if (r) begin
      chk("in_ready",  int'(in_ready),  e_rdy);
      chk("shift_en",  int'(shift_en),  e_sh);
      chk("zero_fill", int'(zero_fill), e_zf);
      chk("pix_edge",  int'(pix_edge),  e_ed);
      if (shift_en) tot_shift++;
      if (!in_ready) rdy_low++;
    end
    @(posedge clk); #1;
    if (!r) begin
      m_active = 0; m_fl = 0; m_n = 0;
      e_wv = 0; e_col = 0; e_row = 0; e_brd = 0; e_done = 0;
    end else begin
      if (m_fl > 0) m_fl--;
      else if (acc && s) begin m_active = 1; m_n = 1; end
      else if (acc && m_active) begin
        if (m_n == W*H-1) begin m_active = 0; m_fl = W+1; end
        else m_n++;
      end
      e_wv = w; e_done = dn;
      if (w) begin
        e_col = c % W; e_row = c / W;
        e_brd = (e_col == 0 || e_col == W-1 || e_row == 0 || e_row == H-1);
      end
    end
    chk("win_valid",     int'(win_valid),     e_wv);
    chk("center_col",    int'(center_col),    e_col);
    chk("center_row",    int'(center_row),    e_row);
    chk("center_border", int'(center_border), e_brd);
    chk("frame_done",    int'(frame_done),    e_done);
    if (win_valid) begin
      tot_win++;
      brd[center_row % 3][center_col] = int'(center_border);
    end
    if (frame_done) begin tot_done++; done_col = int'(center_col); done_row = int'(center_row); end
  endtask

  task automatic frame(input bit toggle);
    int k;
    k = 0;
    while (k < W*H) begin
      if (toggle) begin step(1'b1, k == 0); step(1'b0, 1'b0); end
      else step(1'b1, k == 0);
      k++;
    end
  endtask

  initial begin
    foreach (brd[i, j]) brd[i][j] = -1;
    // reset
    step(0, 0, 0);
    step(0, 0, 0);
    chk("reset win_valid", int'(win_valid), 0);
    chk("reset frame_done", int'(frame_done), 0);

    // back-to-back frame
    clr_obs();
    for (int k = 0; k < W*H; k++) begin
      step(1'b1, k == 0);
      if (k == 4) chk("no window at n=4", int'(win_valid), 0);
      if (k == 5) begin
        chk("first window n=5", int'(win_valid), 1);
        chk("first centre col", int'(center_col), 0);
        chk("first centre row", int'(center_row), 0);
      end
    end
    for (int k = 0; k < 8; k++) step(0, 0);
    chk("b2b shifts", tot_shift, 17);
    chk("b2b windows", tot_win, 12);
    chk("b2b frame_done", tot_done, 1);
    chk("done centre col", done_col, 3);
    chk("done centre row", done_row, 2);
    chk("border (0,0)", brd[0][0], 1);
    chk("border (1,0)", brd[0][1], 1);
    chk("border (3,1)", brd[1][3], 1);
    chk("border (0,1)", brd[1][0], 1);
    chk("border (1,1)", brd[1][1], 0);
    chk("border (2,1)", brd[1][2], 0);

    // pix_valid toggling
    clr_obs();
    frame(1'b1);
    for (int k = 0; k < 8; k++) step(0, 0);
    chk("toggle shifts", tot_shift, 17);
    chk("toggle windows", tot_win, 12);
    chk("toggle frame_done", tot_done, 1);

    // abort with sof at n=7
    clr_obs();
    for (int k = 0; k < 7; k++) step(1'b1, k == 0);
    step(1, 1);
    chk("abort windows so far", tot_win, 2);
    for (int k = 1; k <= 5; k++) begin
      step(1, 0);
      if (k == 4) chk("abort refill no window", int'(win_valid), 0);
    end
    chk("abort refill window", int'(win_valid), 1);
    chk("abort refill col", int'(center_col), 0);
    chk("abort refill row", int'(center_row), 0);
    for (int k = 6; k < W*H; k++) step(1, 0);
    for (int k = 0; k < 8; k++) step(0, 0);
    chk("abort frame_done", tot_done, 1);
    chk("abort windows", tot_win, 14);

    // pix_valid held through FLUSH, then IDLE drops non-sof pixels
    clr_obs();
    frame(1'b0);
    for (int k = 0; k < 5; k++) step(1, 0);
    chk("flush in_ready low", rdy_low, 5);
    for (int k = 0; k < 3; k++) step(1, 0);
    chk("flush windows", tot_win, 12);
    chk("idle drop shifts", tot_shift, 17);
    step(1, 1);
    chk("idle sof accepted", int'(in_ready), 1);

    // reset during RUN
    for (int k = 1; k < 8; k++) step(1, 0);
    step(1, 0, 0);
    chk("mid-run reset win_valid", int'(win_valid), 0);
    chk("mid-run reset col", int'(center_col), 0);
    clr_obs();
    frame(1'b0);
    for (int k = 0; k < 8; k++) step(0, 0);
    chk("post-reset windows", tot_win, 12);
    chk("post-reset frame_done", tot_done, 1);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 499) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line (≥3).
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame (≥2).
REQ-003 SHALL have the port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have the port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have the port pix_valid, input, 1, upstream pixel present.
REQ-006 SHALL have the port sof, input, 1, qualifies the current pix_valid pixel as first of a frame.
REQ-007 SHALL have the port in_ready, output, 1, controller accepts pixel; accept = pix_valid && in_ready.
REQ-008 SHALL have the port shift_en, output, 1, line-buffer shift strobe.
REQ-009 SHALL have the port zero_fill, output, 1, buffer loads zero instead of pixel data.
REQ-010 SHALL have the port pix_edge, output, 1, accepted pixel is at column 0 or IMG_W-1.
REQ-011 SHALL have the port win_valid, output, 1, 3x3 window centre is valid.
REQ-012 SHALL have the ports center_col and center_row, outputs, $clog2(IMG_W) and $clog2(IMG_H) bits, window centre coordinates.
REQ-013 SHALL have the port center_border, output, 1, centre lies on the image border: row 0, row IMG_H-1, col 0, or col IMG_W-1.
REQ-014 SHALL have the port frame_done, output, 1, single-cycle pulse after the last centre.

Function
REQ-015 The FSM SHALL have the states IDLE, FILL, RUN and FLUSH.
REQ-016 in_ready SHALL be 1 in IDLE, FILL and RUN, and 0 in FLUSH.
REQ-017 In IDLE, an accept without sof SHALL be dropped: no shift_en, no state change.
REQ-018 In IDLE, an accept with sof SHALL count as input index n=0, assert shift_en, and go to FILL.
REQ-019 shift_en, zero_fill and pix_edge SHALL be combinational: shift_en = accept in FILL/RUN (or IDLE+sof), or 1 in FLUSH.
REQ-020 Input indices n=0..IMG_W SHALL be FILL pixels with no window; accepting n=IMG_W SHALL move to RUN.
REQ-021 In RUN, each accept of index n SHALL produce a window with centre index c=n-(IMG_W+1), raster order.
REQ-022 Accepting n=IMG_W*IMG_H-1 SHALL move to FLUSH.
REQ-023 FLUSH SHALL run exactly IMG_W+1 cycles, each with shift_en=1, zero_fill=1 and one window, then go to IDLE.
REQ-024 Each frame SHALL therefore emit exactly IMG_W*IMG_H windows.
REQ-025 win_valid, center_col, center_row and center_border SHALL be registered, asserted the cycle after the causing shift_en.
REQ-026 frame_done SHALL pulse in the cycle after the final FLUSH shift, coincident with the last win_valid.
REQ-027 An accept with sof in FILL or RUN SHALL abort the frame: that pixel becomes n=0, centre counters clear, state goes to FILL, and no frame_done is issued.
REQ-028 sof SHALL be ignored in FLUSH, since nothing is accepted there.
REQ-029 Column counters SHALL wrap IMG_W-1→0 and increment the row; the row SHALL wrap IMG_H-1→0 only at frame end.
REQ-030 Counters SHALL not be truncated at any width.
REQ-031 With no accept in FILL or RUN, no counter SHALL change and win_valid SHALL be 0.

Reset
REQ-032 While rst=0 at a clock edge: state=IDLE, counters=0, win_valid=0, center_col=0, center_row=0, center_border=0, frame_done=0.
REQ-033 Reset SHALL take priority over all other inputs, including mid-FILL, mid-RUN and mid-FLUSH.
REQ-034 The cycle after reset releases, in_ready SHALL be 1.

Structure
REQ-035 Package conv_pkg SHALL hold the IMG_W/IMG_H defaults and the FSM state enum.
REQ-036 Sub-module raster_counter SHALL provide a col/row counter with enable, clear and last-pixel flag.
REQ-037 raster_counter SHALL be instantiated twice: once for input position, once for centre position.
REQ-038 The controller SHALL contain no pixel storage; data stays in the line buffer.

Verification (IMG_W=4, IMG_H=3 unless stated)
REQ-039 Scenario: reset, then 12 back-to-back accepts with sof on the first -> shift_en on 12 accepts plus 5 FLUSH cycles; first win_valid the cycle after accept n=5, centre (0,0); 12 windows total; frame_done with centre (3,2).
REQ-040 Scenario: pix_valid toggling 1/0 each cycle -> windows occur only after accepted pixels; coordinates are contiguous; totals are identical to REQ-039.
REQ-041 Scenario: sof reasserted at input n=7 -> no frame_done for the aborted frame; the next window appears after 5 more fill accepts, centre (0,0).
REQ-042 Scenario: pix_valid=1 throughout FLUSH -> in_ready=0 for 5 cycles, no extra windows; accept resumes in IDLE only with sof.
REQ-043 Scenario: rst=0 asserted during RUN -> all outputs are at reset values the next cycle; a subsequent frame behaves per REQ-039.
REQ-044 Scenario: the first line's centres -> center_border=1 for all of row 0 and for cols 0 and 3; center (1,1) and (2,1) report center_border=0.
